// File: rtl/score_table_ctrl_if.sv
// Client-facing channels of the score table controller:
// insert requests from game logic and rank lookups from display logic.
interface score_table_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 4
);

    logic                  ins_valid;
    logic [DATA_WIDTH-1:0] ins_score;
    logic                  ins_ready;
    logic                  ins_done;
    logic                  ins_placed;
    logic [IDX_W-1:0]      ins_rank;

    logic                  lk_valid;
    logic [IDX_W-1:0]      lk_idx;
    logic                  lk_ready;
    logic                  lk_rsp_valid;
    logic [DATA_WIDTH-1:0] lk_rsp_data;

    // Client side: game logic and display logic.
    modport master (
        output ins_valid,
        output ins_score,
        input  ins_ready,
        input  ins_done,
        input  ins_placed,
        input  ins_rank,
        output lk_valid,
        output lk_idx,
        input  lk_ready,
        input  lk_rsp_valid,
        input  lk_rsp_data
    );

    // Controller side.
    modport slave (
        input  ins_valid,
        input  ins_score,
        output ins_ready,
        output ins_done,
        output ins_placed,
        output ins_rank,
        input  lk_valid,
        input  lk_idx,
        output lk_ready,
        output lk_rsp_valid,
        output lk_rsp_data
    );

endinterface

// File: rtl/score_table_ctrl.sv
// Score SRAM controller: keeps a descending high-score table in SRAM,
// serving sorted inserts and single-rank lookups over one SRAM port.
module score_table_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int BASE_ADDR   = 0,
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    score_table_ctrl_if.slave     bus,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IDX_W-1:0]      LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0]      MISS = IDX_W'(NUM_ENTRIES);
    localparam logic [IDX_W-1:0]      ONE  = IDX_W'(1);

    typedef enum logic [3:0] {
        IDLE,
        LK_ADDR,
        LK_DATA,
        SC_ADDR,
        SC_CMP,
        SH_RD,
        SH_WR,
        WR_NEW,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;

    // cnt is the scan rank k, the shift target j, or the lookup index.
    logic [IDX_W-1:0]      cnt;
    logic [IDX_W-1:0]      pos;
    logic [DATA_WIDTH-1:0] score;
    logic                  placed;
    logic [IDX_W-1:0]      rank;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  idle;
    logic                  take_ins;
    logic                  take_lk;
    logic                  hit;
    logic                  at_last;
    logic                  sh_end;

    assign idle     = (state == IDLE);
    assign take_ins = idle & bus.ins_valid;
    assign take_lk  = idle & ~bus.ins_valid & bus.lk_valid;
    assign hit      = (score > mem_rdata);
    assign at_last  = (cnt == LAST);
    assign sh_end   = (cnt == pos + ONE);

    assign bus.ins_ready    = idle;
    assign bus.lk_ready     = idle & ~bus.ins_valid;
    assign bus.ins_done     = (state == DONE);
    assign bus.ins_placed   = placed;
    assign bus.ins_rank     = rank;
    assign bus.lk_rsp_valid = rsp_valid;
    assign bus.lk_rsp_data  = rsp_data;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; inserts win arbitration over lookups.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take_ins) begin
                    state_nx = SC_ADDR;
                end else if (take_lk) begin
                    state_nx = LK_ADDR;
                end
            end
            LK_ADDR: state_nx = LK_DATA;
            LK_DATA: state_nx = IDLE;
            SC_ADDR: state_nx = SC_CMP;
            SC_CMP: begin
                if (hit) begin
                    state_nx = at_last ? WR_NEW : SH_RD;
                end else if (at_last) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SC_ADDR;
                end
            end
            SH_RD:  state_nx = SH_WR;
            SH_WR:  state_nx = sh_end ? WR_NEW : SH_RD;
            WR_NEW: state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: request capture, scan/shift counters, results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            pos       <= '0;
            score     <= '0;
            placed    <= 1'b0;
            rank      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take_ins) begin
                        score <= bus.ins_score;
                        cnt   <= '0;
                    end else if (take_lk) begin
                        cnt <= bus.lk_idx;
                    end
                end
                LK_DATA: begin
                    rsp_data  <= mem_rdata;
                    rsp_valid <= 1'b1;
                end
                SC_CMP: begin
                    if (hit) begin
                        pos <= cnt;
                        cnt <= LAST;
                    end else if (at_last) begin
                        placed <= 1'b0;
                        rank   <= MISS;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                SH_WR: begin
                    cnt <= cnt - ONE;
                end
                WR_NEW: begin
                    placed <= 1'b1;
                    rank   <= pos;
                end
                default: begin
                end
            endcase
        end
    end

    // SRAM command decode from registered state and counters only.
    // mem_rdata is the SRAM's own output register, so shifting it
    // straight back into the write port closes no combinational loop.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = BASE;
        mem_wdata = '0;
        unique case (state)
            LK_ADDR, SC_ADDR: begin
                mem_en   = 1'b1;
                mem_addr = BASE + ADDR_WIDTH'(cnt);
            end
            SH_RD: begin
                mem_en   = 1'b1;
                mem_addr = BASE + ADDR_WIDTH'(cnt - ONE);
            end
            SH_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = BASE + ADDR_WIDTH'(cnt);
                mem_wdata = mem_rdata;
            end
            WR_NEW: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = BASE + ADDR_WIDTH'(pos);
                mem_wdata = score;
            end
            default: begin
            end
        endcase
    end

endmodule
